// File: rtl/time_pkg.sv
// Shared constants and types for the time-mode load block.
// Contents:
//   HEPT_MOD, TRIPL_MOD : default moduli of the heptal and triple fields
//   HEPT_W, TRIPL_W     : field widths
//   state_e             : mode FSM encoding (StRun = 0, StSet = 1)
package time_pkg;

  localparam int unsigned HEPT_MOD  = 7;
  localparam int unsigned TRIPL_MOD = 3;
  localparam int unsigned HEPT_W    = 3;
  localparam int unsigned TRIPL_W   = 2;

  typedef enum logic {
    StRun = 1'b0,
    StSet = 1'b1
  } state_e;

endpackage

// File: rtl/time_mode_load_mod_counter.sv
// Modulo-N counter with synchronous load. Used for both time fields.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset (count -> 0)
//   inc       : advance by one, wrapping at Modulus-1 -> 0
//   load      : load load_val (takes priority over inc)
//   load_val  : value to load; the caller guarantees it is in range
//   count     : registered count
//   wrap_out  : combinational, high when inc will wrap the count this cycle
module mod_counter #(
  parameter int unsigned Modulus = 7,
  parameter int unsigned Width   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             load,
  input  logic [Width-1:0] load_val,
  output logic [Width-1:0] count,
  output logic             wrap_out
);

  localparam logic [Width-1:0] Max = Width'(Modulus - 1);

  logic [Width-1:0] count_q, count_d;
  logic             at_max;

  assign at_max   = (count_q == Max);
  assign wrap_out = inc && at_max;
  assign count    = count_q;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (inc) begin
      count_d = at_max ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/time_mode_load.sv
// Time-mode field register with RUN/SET modes.
// In RUN, tick advances the heptal field; its wrap carries into the triple field.
// In SET, ld loads one field (selected by mod) from din after a range check.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   set_en        : 1 requests SET, 0 requests RUN
//   tick          : one-cycle advance pulse (RUN only)
//   mod           : load target, 0 = heptal, 1 = triple
//   ld            : one-cycle load strobe (SET only)
//   din           : load value
//   hept, tripl   : registered fields; {tripl, hept} feeds the output selector
//   ack, err      : registered one-cycle load accepted / rejected pulses
//   wrap          : registered one-cycle pulse when both fields wrap together
//   in_set        : high while in SET
module time_mode_load #(
  parameter int unsigned HEPT_MOD  = time_pkg::HEPT_MOD,
  parameter int unsigned TRIPL_MOD = time_pkg::TRIPL_MOD
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       set_en,
  input  logic       tick,
  input  logic       mod,
  input  logic       ld,
  input  logic [2:0] din,
  output logic [2:0] hept,
  output logic [1:0] tripl,
  output logic       ack,
  output logic       err,
  output logic       wrap,
  output logic       in_set
);

  import time_pkg::*;

  localparam logic [2:0] HeptMax  = 3'(HEPT_MOD - 1);
  localparam logic [1:0] TriplMax = 2'(TRIPL_MOD - 1);

  state_e state_q, state_d;
  logic   ack_q, err_q, wrap_q;
  logic   hept_inc, hept_load, hept_wrap;
  logic   tripl_load, tripl_wrap;
  logic   load_req, load_ok;

  // Mode FSM: inputs are always judged in the current state, so a tick or ld
  // coinciding with a mode change is still honoured by the old mode.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun: if (set_en)  state_d = StSet;
      StSet: if (!set_en) state_d = StRun;
      default: state_d = StRun;
    endcase
  end

  assign load_req   = (state_q == StSet) && ld;
  assign hept_load  = load_req && !mod && (din <= HeptMax);
  assign tripl_load = load_req && mod && !din[2] && (din[1:0] <= TriplMax);
  assign load_ok    = hept_load || tripl_load;
  assign hept_inc   = (state_q == StRun) && tick;

  mod_counter #(
    .Modulus (HEPT_MOD),
    .Width   (HEPT_W)
  ) u_hept (
    .clk      (clk),
    .rst      (rst),
    .inc      (hept_inc),
    .load     (hept_load),
    .load_val (din),
    .count    (hept),
    .wrap_out (hept_wrap)
  );

  // Triple field advances only on the heptal carry.
  mod_counter #(
    .Modulus (TRIPL_MOD),
    .Width   (TRIPL_W)
  ) u_tripl (
    .clk      (clk),
    .rst      (rst),
    .inc      (hept_wrap),
    .load     (tripl_load),
    .load_val (din[1:0]),
    .count    (tripl),
    .wrap_out (tripl_wrap)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StRun;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= load_ok;
      err_q   <= load_req && !load_ok;
      wrap_q  <= tripl_wrap;
    end
  end

  assign ack    = ack_q;
  assign err    = err_q;
  assign wrap   = wrap_q;
  assign in_set = (state_q == StSet);

endmodule

// File: tb/tb_time_mode_load.sv
module tb_time_mode_load;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       set_en = 1'b0, tick = 1'b0, mod = 1'b0, ld = 1'b0;
  logic [2:0] din = 3'd0;
  logic [2:0] hept;
  logic [1:0] tripl;
  logic       ack, err, wrap, in_set;

  int checks = 0;
  int failures = 0;

  // Reference model: the two fields as one position in a 21-step cycle.
  int m_h, m_t;
  bit m_set, m_ack, m_err, m_wrap;

  time_mode_load dut (
    .clk    (clk),
    .rst    (rst),
    .set_en (set_en),
    .tick   (tick),
    .mod    (mod),
    .ld     (ld),
    .din    (din),
    .hept   (hept),
    .tripl  (tripl),
    .ack    (ack),
    .err    (err),
    .wrap   (wrap),
    .in_set (in_set)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_h = 0; m_t = 0; m_set = 0; m_ack = 0; m_err = 0; m_wrap = 0;
  endtask

  // Drive one cycle of inputs, advance the model at the edge, return at edge+1.
  task automatic cycle(input bit s, input bit tk, input bit md, input bit l,
                       input logic [2:0] d);
    @(negedge clk);
    set_en = s; tick = tk; mod = md; ld = l; din = d;
    @(posedge clk);
    m_ack = 0; m_err = 0; m_wrap = 0;
    if (m_set) begin
      if (l) begin
        if (!md && d <= 6) begin m_h = d; m_ack = 1; end
        else if (md && d <= 2) begin m_t = d; m_ack = 1; end
        else m_err = 1;
      end
    end else if (tk) begin
      int pos;
      pos = m_t * 7 + m_h + 1;
      m_wrap = (pos == 21);
      pos = pos % 21;
      m_h = pos % 7;
      m_t = pos / 7;
    end
    m_set = s;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; set_en = 0; tick = 0; ld = 0; mod = 0; din = 0;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({hept, tripl, ack, err, wrap, in_set} !== 9'd0) begin
      failures++;
      $display("FAIL reset_state got=%b want=0", {hept, tripl, ack, err, wrap, in_set});
    end
    cycle(0, 0, 0, 0, 0);
    checks++;
    if ({ack, err, wrap} !== 3'b000) begin
      failures++;
      $display("FAIL reset_no_pulse got=%b want=000", {ack, err, wrap});
    end
  endtask

  task automatic test_run_ticks();
    do_reset();
    for (int i = 1; i <= 7; i++) begin
      cycle(0, 1, 0, 0, 0);
      checks++;
      if (hept !== 3'(i % 7) || tripl !== 2'(i / 7)) begin
        failures++;
        $display("FAIL run_tick%0d got=%0d/%0d want=%0d/%0d", i, tripl, hept, i / 7, i % 7);
      end
    end
  endtask

  task automatic test_full_wrap();
    int wraps;
    wraps = 0;
    do_reset();
    for (int i = 0; i < 23; i++) begin
      cycle(0, (i < 21), 0, 0, 0);
      if (wrap === 1'b1) wraps++;
    end
    checks++;
    if (wraps != 1 || hept !== 3'd0 || tripl !== 2'd0) begin
      failures++;
      $display("FAIL full_wrap wraps=%0d fields=%0d/%0d want wraps=1 fields=0/0",
               wraps, tripl, hept);
    end
  endtask

  task automatic test_set_load();
    do_reset();
    cycle(1, 0, 0, 0, 0);
    checks++;
    if (in_set !== 1'b1) begin
      failures++;
      $display("FAIL enter_set in_set=%b want=1", in_set);
    end
    cycle(1, 0, 0, 1, 3'd5);
    checks++;
    if (hept !== 3'd5 || tripl !== 2'd0 || ack !== 1'b1 || err !== 1'b0) begin
      failures++;
      $display("FAIL load_hept5 got h=%0d t=%0d ack=%b err=%b want h=5 t=0 ack=1 err=0",
               hept, tripl, ack, err);
    end
    cycle(1, 0, 1, 1, 3'd2);
    checks++;
    if (hept !== 3'd5 || tripl !== 2'd2 || ack !== 1'b1 || err !== 1'b0) begin
      failures++;
      $display("FAIL load_tripl2 got h=%0d t=%0d ack=%b err=%b want h=5 t=2 ack=1 err=0",
               hept, tripl, ack, err);
    end
    cycle(1, 0, 0, 0, 0);
    checks++;
    if (ack !== 1'b0) begin
      failures++;
      $display("FAIL ack_one_cycle ack=%b want=0", ack);
    end
  endtask

  task automatic test_errors();
    logic [3:0] bad [3];
    bad[0] = {1'b0, 3'd7}; bad[1] = {1'b1, 3'd3}; bad[2] = {1'b1, 3'd4};
    // Fields are 5/2 from the previous test and must survive every rejected load.
    for (int i = 0; i < 3; i++) begin
      cycle(1, 0, bad[i][3], 1, bad[i][2:0]);
      checks++;
      if (err !== 1'b1 || ack !== 1'b0 || hept !== 3'd5 || tripl !== 2'd2) begin
        failures++;
        $display("FAIL reject%0d got err=%b ack=%b h=%0d t=%0d want err=1 ack=0 h=5 t=2",
                 i, err, ack, hept, tripl);
      end
    end
  endtask

  task automatic test_ignored();
    cycle(1, 1, 0, 0, 0);
    checks++;
    if (hept !== 3'd5 || tripl !== 2'd2 || {ack, err, wrap} !== 3'b000) begin
      failures++;
      $display("FAIL tick_in_set got h=%0d t=%0d pulses=%b want h=5 t=2 pulses=000",
               hept, tripl, {ack, err, wrap});
    end
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 3'd1);
    checks++;
    if (hept !== 3'd5 || tripl !== 2'd2 || {ack, err} !== 2'b00 || in_set !== 1'b0) begin
      failures++;
      $display("FAIL ld_in_run got h=%0d t=%0d ack/err=%b want h=5 t=2 ack/err=00",
               hept, tripl, {ack, err});
    end
  endtask

  task automatic test_boundary();
    // Tick on the RUN->SET edge is still a RUN tick.
    cycle(1, 1, 0, 0, 0);
    checks++;
    if (hept !== 3'd6 || in_set !== 1'b1) begin
      failures++;
      $display("FAIL tick_on_enter_set got h=%0d in_set=%b want h=6 in_set=1", hept, in_set);
    end
    // Load on the SET->RUN edge is still a SET load.
    cycle(0, 0, 0, 1, 3'd3);
    checks++;
    if (hept !== 3'd3 || ack !== 1'b1 || in_set !== 1'b0) begin
      failures++;
      $display("FAIL ld_on_leave_set got h=%0d ack=%b in_set=%b want h=3 ack=1 in_set=0",
               hept, ack, in_set);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 2) == 0), $urandom_range(0, 1) == 1,
            $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)));
      checks++;
      if ({hept, tripl, ack, err, wrap, in_set} !==
          {3'(m_h), 2'(m_t), m_ack, m_err, m_wrap, m_set}) begin
        failures++;
        $display("FAIL random%0d got=%b want=%b", i, {hept, tripl, ack, err, wrap, in_set},
                 {3'(m_h), 2'(m_t), m_ack, m_err, m_wrap, m_set});
      end
    end
  endtask

  task automatic test_reset_mid_set();
    do_reset();
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 1, 1, 3'd1);
    cycle(1, 0, 0, 1, 3'd4);
    checks++;
    if (hept !== 3'd4 || tripl !== 2'd1 || in_set !== 1'b1 || ack !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset got h=%0d t=%0d in_set=%b ack=%b want h=4 t=1 in_set=1 ack=1",
               hept, tripl, in_set, ack);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({hept, tripl, ack, err, wrap, in_set} !== 9'd0) begin
      failures++;
      $display("FAIL async_reset got=%b want=0", {hept, tripl, ack, err, wrap, in_set});
    end
    @(negedge clk);
    set_en = 0; ld = 0;
    rst = 1'b0;
    model_reset();
    cycle(0, 0, 0, 0, 0);
    checks++;
    if ({hept, tripl, ack, err, wrap, in_set} !== 9'd0) begin
      failures++;
      $display("FAIL after_reset got=%b want=0", {hept, tripl, ack, err, wrap, in_set});
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_run_ticks();
    test_full_wrap();
    test_set_load();
    test_errors();
    test_ignored();
    test_boundary();
    test_random();
    test_reset_mid_set();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
